led_serial_shifter: RTL

Serialiser between the parallel LED/GPIO output register and the external daisy-chained LED shift registers. Accepts a parallel LED word with a start strobe and shifts it out on a divided serial clock, then pulses a latch-enable to the external chain. Buffers one pending word so the register side never stalls. Drives the board-level led_clk / led_sout / led_clrn / led_pen pins.

---
 rtl/led_serial_shifter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/led_serial_shifter.sv
// -----------------------------------------------------------------------------
// led_serial_shifter
//
// Serialiser between the parallel LED/GPIO output register and the external
// daisy-chained LED shift registers. A parallel word is captured on `start`,
// shifted out on a divided serial clock, and then a latch-enable pulse is sent
// to the external chain. One extra word can be buffered while a frame is in
// flight, so the register side never has to stall.
//
// Parameters:
//   WIDTH    bits per frame (>= 2)
//   DIV      led_clk half-period in clk cycles (>= 1)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   one-cycle request to send `data`
//   data      in   parallel LED word, sampled with start
//   busy      out  frame in progress (INIT, SHIFT or LATCH)
//   done      out  one-cycle pulse at the end of each frame
//   pend      out  a buffered word is waiting
//   led_clk   out  serial clock, chain shifts on its rising edge
//   led_sout  out  serial data
//   led_clrn  out  active-low clear to the chain
//   led_pen   out  latch / output-enable strobe, DIV cycles per frame
//
// Build option:
//   LED_SHIFT_MSB_FIRST_EN  defined: bit WIDTH-1 goes out first (shift left).
//                           undefined: bit 0 goes out first (shift right).
//                           Timing is identical either way.
// -----------------------------------------------------------------------------
module led_serial_shifter #(
    parameter int WIDTH = 16,
    parameter int DIV   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             pend,
    output logic             led_clk,
    output logic             led_sout,
    output logic             led_clrn,
    output logic             led_pen
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam int DIV_W = $clog2(DIV) + 1;

    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] HALF_LAST   = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] PERIOD_LAST = DIV_W'(2 * DIV - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_SHIFT,
        S_LATCH
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [BIT_W-1:0] bit_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] pbuf_q;
    logic             pend_q;
    logic             busy_q;
    logic             done_q;
    logic             clk_q;
    logic             sout_q;
    logic             clrn_q;
    logic             pen_q;

    // Shift direction: the advanced register contents and the bit that
    // leads out of each possible source word.
    logic [WIDTH-1:0] sreg_adv;
    logic             adv_head;
    logic             data_head;
    logic             pbuf_head;

`ifdef LED_SHIFT_MSB_FIRST_EN
    assign sreg_adv  = sreg_q << 1;
    assign adv_head  = sreg_q[WIDTH-2];
    assign data_head = data[WIDTH-1];
    assign pbuf_head = pbuf_q[WIDTH-1];
`else
    assign sreg_adv  = sreg_q >> 1;
    assign adv_head  = sreg_q[1];
    assign data_head = data[0];
    assign pbuf_head = pbuf_q[0];
`endif

    // Every output is a register; the next value of each is set together with
    // the state transition that implies it, so the pins never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            div_q   <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
            pbuf_q  <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            clk_q   <= 1'b0;
            sout_q  <= 1'b0;
            clrn_q  <= 1'b0;
            pen_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // Hold the external chain in clear for DIV cycles; start is
                // not looked at here.
                S_INIT: begin
                    if (div_q == HALF_LAST) begin
                        state_q <= S_IDLE;
                        clrn_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        div_q   <= '0;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end

                S_IDLE: begin
                    if (start) begin
                        state_q <= S_SHIFT;
                        busy_q  <= 1'b1;
                        sreg_q  <= data;
                        sout_q  <= data_head;
                        div_q   <= '0;
                        bit_q   <= '0;
                    end
                end

                // Each bit period is 2*DIV cycles: led_clk low for the first
                // half, high for the second; data advances as the period ends.
                S_SHIFT: begin
                    if (start) begin
                        pbuf_q <= data;
                        pend_q <= 1'b1;
                    end
                    if (div_q == PERIOD_LAST) begin
                        div_q <= '0;
                        clk_q <= 1'b0;
                        if (bit_q == LAST_BIT) begin
                            state_q <= S_LATCH;
                            pen_q   <= 1'b1;
                            sout_q  <= 1'b0;
                        end else begin
                            bit_q  <= bit_q + 1'b1;
                            sreg_q <= sreg_adv;
                            sout_q <= adv_head;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                        if (div_q == HALF_LAST) begin
                            clk_q <= 1'b1;
                        end
                    end
                end

                // On exit a buffered word is sent with no idle gap. A start
                // arriving in the exit cycle is still honoured: it becomes the
                // new pending word, or is sent directly when nothing is pending.
                S_LATCH: begin
                    if (div_q == HALF_LAST) begin
                        div_q  <= '0;
                        pen_q  <= 1'b0;
                        done_q <= 1'b1;
                        if (pend_q) begin
                            state_q <= S_SHIFT;
                            bit_q   <= '0;
                            sreg_q  <= pbuf_q;
                            sout_q  <= pbuf_head;
                            pend_q  <= start;
                            if (start) begin
                                pbuf_q <= data;
                            end
                        end else if (start) begin
                            state_q <= S_SHIFT;
                            bit_q   <= '0;
                            sreg_q  <= data;
                            sout_q  <= data_head;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                        if (start) begin
                            pbuf_q <= data;
                            pend_q <= 1'b1;
                        end
                    end
                end

                default: state_q <= S_INIT;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign pend     = pend_q;
    assign led_clk  = clk_q;
    assign led_sout = sout_q;
    assign led_clrn = clrn_q;
    assign led_pen  = pen_q;

endmodule
